// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for the
// single-port data memory. Port 0 is the core load/store path, port 1 the
// debug/loader path. Each access takes IDLE -> ACCESS -> RESP, one cycle each
// after the grant, and every output toggles only on a clock edge or on reset.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic                oor_q, oor_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                busy_q, busy_d;

    logic                grant_s;
    logic                gnt_sel_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                sel_oor_s;
    logic [DATA_W-1:0]   rd_val_s;

    // Pick the winner among the current requesters; prio only breaks ties.
    always_comb begin
        grant_s = req0 | req1;
        if (req0 && req1) begin
            gnt_sel_s = prio_q;
        end else if (req1) begin
            gnt_sel_s = 1'b1;
        end else begin
            gnt_sel_s = 1'b0;
        end
        if (gnt_sel_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
        sel_oor_s = (sel_addr_s >= ADDR_W'(DEPTH));
        if (!we_q && !oor_q) begin
            rd_val_s = mem_rdata;
        end else begin
            rd_val_s = {DATA_W{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: ACCESS and RESP each last exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the latched request and all registered outputs.
    always_comb begin
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        oor_d       = oor_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ack0_d      = ack0_q;
        ack1_d      = ack1_q;
        err0_d      = err0_q;
        err1_d      = err1_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    // Latch the winner so later changes on its inputs are ignored.
                    gnt_d       = gnt_sel_s;
                    prio_d      = ~gnt_sel_s;
                    we_d        = sel_we_s;
                    oor_d       = sel_oor_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                    mem_write_d = sel_we_s & ~sel_oor_s;
                    mem_read_d  = ~sel_we_s & ~sel_oor_s;
                    busy_d      = 1'b1;
                end else begin
                    busy_d      = 1'b0;
                end
            end
            ST_ACCESS: begin
                // Strobes drop here; the memory write already committed on the negedge.
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (gnt_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = oor_q;
                    rdata1_d = rd_val_s;
                    ack0_d   = 1'b0;
                    err0_d   = 1'b0;
                    rdata0_d = {DATA_W{1'b0}};
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = oor_q;
                    rdata0_d = rd_val_s;
                    ack1_d   = 1'b0;
                    err1_d   = 1'b0;
                    rdata1_d = {DATA_W{1'b0}};
                end
            end
            ST_RESP: begin
                // rdata is left holding the last response.
                ack0_d = 1'b0;
                ack1_d = 1'b0;
                err0_d = 1'b0;
                err1_d = 1'b0;
                busy_d = 1'b0;
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                ack0_d      = 1'b0;
                ack1_d      = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset clears everything at once, aborting any strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= {DATA_W{1'b0}};
            rdata1_q    <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a 64-word memory with negedge writes sits behind
// the arbiter, and a transaction-level model (round-robin priority bit plus a
// shadow word array) predicts which port is answered and with what data.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    bit          prio_m;
    int          checks = 0;
    int          errors = 0;
    int          wr_strobes = 0;
    int          oor_strobes = 0;
    logic [31:0] last_rdata0;
    logic [7:0]  win_hist;
    int          s_wr;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
    end

    assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'd0;

    always @(negedge clk) begin
        if (mem_write && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;
        if (mem_write) wr_strobes <= wr_strobes + 1;
        if ((mem_write || mem_read) && mem_addr >= 32'd64) oor_strobes <= oor_strobes + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack0"}, 32'(ack0), 32'd0);
        chk({tag, "_ack1"}, 32'(ack1), 32'd0);
        chk({tag, "_err0"}, 32'(err0), 32'd0);
        chk({tag, "_err1"}, 32'(err1), 32'd0);
        chk({tag, "_rdata0"}, rdata0, 32'd0);
        chk({tag, "_rdata1"}, rdata1, 32'd0);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic set_p0(input logic w, input logic [31:0] a, input logic [31:0] d);
        we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set_p1(input logic w, input logic [31:0] a, input logic [31:0] d);
        we1 = w; addr1 = a; wdata1 = d;
    endtask

    // Raise the requested ports and collect n acks, checking each against the model.
    // With hold=1 the requests stay up after their ack; otherwise an acked port drops.
    task automatic run(input bit r0, input bit r1, input bit hold, input int n);
        bit          p0, p1, w, wr, e_err;
        int          seen, gap, guard, idle;
        logic [31:0] a, d, e_rd;
        p0 = r0; p1 = r1;
        seen = 0; gap = 0; guard = 0; idle = 0;
        req0 = r0; req1 = r1;
        while (seen < n && guard < 60) begin
            tick();
            guard++; gap++;
            if (!busy) idle++;
            if (ack0 || ack1) begin
                if (p0 && p1) w = prio_m;
                else          w = p0 ? 1'b0 : 1'b1;
                a  = w ? addr1  : addr0;
                wr = w ? we1    : we0;
                d  = w ? wdata1 : wdata0;
                e_err = (a >= 32'd64);
                e_rd  = (!wr && !e_err) ? ref_mem[a[5:0]] : 32'd0;
                chk("win_ack",    32'(w ? ack1 : ack0), 32'd1);
                chk("lose_ack",   32'(w ? ack0 : ack1), 32'd0);
                chk("win_rdata",  w ? rdata1 : rdata0, e_rd);
                chk("lose_rdata", w ? rdata0 : rdata1, 32'd0);
                chk("win_err",    32'(w ? err1 : err0), 32'(e_err));
                chk("lose_err",   32'(w ? err0 : err1), 32'd0);
                chk("ack_latency", 32'(gap), (seen == 0) ? 32'd2 : 32'd3);
                if (seen != 0) chk("idle_cycles", 32'(idle), 32'd1);
                if (seen < 8) win_hist[seen] = w;
                if (!w) last_rdata0 = rdata0;
                prio_m = ~w;
                if (wr && !e_err) ref_mem[a[5:0]] = d;
                if (!hold) begin
                    if (w) begin p1 = 1'b0; req1 = 1'b0; end
                    else   begin p0 = 1'b0; req0 = 1'b0; end
                end
                seen++; gap = 0; idle = 0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("ack_count", 32'(seen), 32'(n));
        tick();
        chk("ack_pulse_end", 32'({ack0, ack1}), 32'd0);
    endtask

    initial begin
        bit rr0, rr1;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        set_p0(1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 32'd0, 32'd0);
        prio_m = 1'b0; last_rdata0 = 32'd0; win_hist = 8'd0;
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b1;
        tick();

        // Reset asserted in the middle of a write access, before its negedge.
        set_p0(1'b1, 32'd5, 32'hAAAA_5555);
        req0 = 1'b1;
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_wr", 32'(mem_write), 32'd1);
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        req0 = 1'b0;
        repeat (2) tick();
        rst = 1'b1; prio_m = 1'b0;
        tick();
        set_p0(1'b0, 32'd5, 32'd0);
        run(1'b1, 1'b0, 1'b0, 1);
        chk("rst_abort_rd", last_rdata0, 32'hC0DE_0005);

        // Single write then read on port 0.
        set_p0(1'b1, 32'd3, 32'hDEAD_BEEF);
        run(1'b1, 1'b0, 1'b0, 1);
        set_p0(1'b0, 32'd3, 32'd0);
        run(1'b1, 1'b0, 1'b0, 1);
        chk("wr_rd_p0", last_rdata0, 32'hDEAD_BEEF);

        // Simultaneous requests straight after reset, then both held.
        rst = 1'b0; tick(); rst = 1'b1; prio_m = 1'b0; tick();
        set_p0(1'b0, 32'd1, 32'd0);
        set_p1(1'b0, 32'd2, 32'd0);
        run(1'b1, 1'b1, 1'b0, 2);
        chk("first_winner", 32'(win_hist[1:0]), 32'd2);
        run(1'b1, 1'b1, 1'b1, 4);
        chk("alternate", 32'(win_hist[3:0]), 32'hA);

        // Cross-port coherence with prio on port 1.
        set_p0(1'b0, 32'd0, 32'd0);
        run(1'b1, 1'b0, 1'b0, 1);
        set_p0(1'b0, 32'd63, 32'd0);
        set_p1(1'b1, 32'd63, 32'h1234_5678);
        run(1'b1, 1'b1, 1'b0, 2);
        chk("coherence", last_rdata0, 32'h1234_5678);

        // Out-of-range write must not strobe the memory.
        s_wr = wr_strobes;
        set_p1(1'b1, 32'd64, 32'hFFFF_FFFF);
        run(1'b0, 1'b1, 1'b0, 1);
        chk("oor_no_write", 32'(wr_strobes), 32'(s_wr));
        set_p0(1'b0, 32'd0, 32'd0);
        run(1'b1, 1'b0, 1'b0, 1);
        chk("oor_addr0", last_rdata0, 32'hC0DE_0000);

        // Request held through ack: back-to-back accesses every 3 cycles.
        set_p0(1'b0, 32'd7, 32'd0);
        run(1'b1, 1'b0, 1'b1, 3);

        // Randomised mix of reads, writes and out-of-range addresses.
        for (int i = 0; i < 30; i++) begin
            rr0 = 1'($urandom_range(0, 1));
            rr1 = rr0 ? 1'($urandom_range(0, 1)) : 1'b1;
            set_p0(1'($urandom_range(0, 1)), 32'($urandom_range(0, 67)), $urandom);
            set_p1(1'($urandom_range(0, 1)), 32'($urandom_range(0, 67)), $urandom);
            run(rr0, rr1, 1'b0, int'(rr0) + int'(rr1));
        end

        chk("oor_strobes", 32'(oor_strobes), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer for the single-port 64-word data memory.
- Port 0 is the core load/store path; port 1 is the debug/loader path.
- Serialises requests, drives the memory's MemRead/MemWrite/addr/write_data, and registers read data back to the winner with a one-cycle ack.
- Range-checks word addresses; out-of-range requests are answered with an error and never reach memory.

Parameters:
- DATA_W, 32, data width of requesters and memory.
- ADDR_W, 32, word-address width (the memory indexes by word).
- DEPTH, 64, number of valid memory words; legal addresses are 0..DEPTH-1.

Ports:
- clk  in  1  system clock; memory writes occur on negedge, arbiter state on posedge.
- rst  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  DATA_W  port 0 read data, valid while ack0=1.
- err0  out  1  port 0 out-of-range flag, valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: as port 0, for port 1.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_rdata  in  DATA_W  from memory read_data (combinational).
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset (rst=0, async): state=IDLE, prio=port 0, all outputs 0 (ack*, err*, rdata*, mem_*, busy).
- Reset takes effect immediately, including mid-ACCESS. A write aborted before its negedge is not performed.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, grant that port.
  - If both req, grant the port equal to prio.
  - On grant: latch gnt_id, we, addr, wdata; set oor = (addr >= DEPTH); go to ACCESS.
  - prio <= other port than the one granted.
- ACCESS (exactly 1 cycle):
  - mem_addr/mem_wdata drive the latched values.
  - mem_write = we & ~oor; mem_read = ~we & ~oor.
  - The memory write commits on the negedge inside this cycle.
  - At the next posedge: rdata_gnt <= (~we & ~oor) ? mem_rdata : 0; err_gnt <= oor; ack_gnt <= 1; go to RESP.
  - Drop mem_read/mem_write to 0 on the same posedge.
- RESP (exactly 1 cycle):
  - ack/err/rdata are valid on the granted port only; the other port's ack/err/rdata are 0.
  - Next posedge: ack/err <= 0; rdata holds its value; go to IDLE.
  - Requests are not sampled in RESP.
- Latency: req sampled at posedge T -> ack high in cycle T+2..T+3. Peak throughput is one access per 3 cycles.
- Fairness: with both ports continuously requesting, grants strictly alternate. No port waits more than one other access.
- A requester may present a new request in the cycle after its ack; it is sampled at the following IDLE posedge.
- Requester fields changing during ACCESS/RESP are ignored, because the values are latched.
- Deasserting req before ack is illegal. The transaction still completes and acks.
- Write-then-read of the same address from different ports returns the new data, because the accesses are serialised.
- Out-of-range requests: no memory strobe, err=1, rdata=0, and prio still rotates.
- busy = (state != IDLE).

Test Plan:
- Reset: rst=0 mid-ACCESS of write addr 5 data 0xAAAA_5555 -> all outputs 0 at once; after release, a port 0 read of addr 5 returns the prior value, not 0xAAAA_5555.
- Single write/read: port 0 write addr 3 = 0xDEADBEEF, then read addr 3 -> ack0 pulses 1 cycle each, 2 cycles after req; rdata0=0xDEADBEEF; err0=0; ack1 stays 0.
- Simultaneous requests after reset: req0 and req1 both high, reads of addr 1 / addr 2 -> port 0 acked first, port 1 acked 3 cycles later; then with both held, grant order 0,1,0,1.
- Cross-port coherence: port 1 writes addr 63 = 0x12345678 while port 0 requests a read of addr 63 in the same cycle with prio=1 -> port 0 rdata0=0x12345678.
- Out of range: port 1 write addr 64 = 0xFFFFFFFF -> mem_write never asserted, ack1=1 with err1=1 and rdata1=0; a subsequent read of addr 0 is unchanged.
- Request held through ack: req0 kept high after ack0 -> next ack0 arrives 3 cycles after the previous one; busy=0 for exactly one cycle between accesses.
